// File: rtl/uart_cmd_ctrl.sv
// Framed UART command decoder: SYNC, CMD, ADDR, D0..D3, CHK -> register write or baud-rate update.
// An inter-byte timeout drops partial frames. Errors are reported as a one-cycle pulse plus a sticky code.
module uart_cmd_ctrl #(
   parameter int unsigned CLK_FREQ_HZ  = 16_000_000,
   parameter int unsigned DEFAULT_BAUD = 115200,
   parameter int unsigned TIMEOUT_CLKS = 160000,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input  logic        i_Clock,
   input  logic        i_Rst_n,
   input  logic        i_Rx_DV,
   input  logic [7:0]  i_Rx_Byte,
   output logic [31:0] o_Baudrate,
   output logic        o_Wr_En,
   output logic [7:0]  o_Wr_Addr,
   output logic [31:0] o_Wr_Data,
   output logic        o_Frame_Err,
   output logic [1:0]  o_Err_Code,
   output logic        o_Busy,
   output logic [15:0] o_Frame_Cnt
);

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_CHK, S_EXEC} state_t;

   localparam logic [31:0] BAUD_MIN  = 32'd1200;
   localparam logic [31:0] BAUD_MAX  = 32'(CLK_FREQ_HZ / 8);
   localparam logic [31:0] BAUD_RST  = 32'(DEFAULT_BAUD);
   localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CLKS - 1);
   localparam logic [7:0]  CMD_WRITE = 8'h01;
   localparam logic [7:0]  CMD_BAUD  = 8'h02;

   state_t      state_q;
   logic [7:0]  cmd_q;
   logic [7:0]  addr_q;
   logic [31:0] data_q;
   logic [1:0]  idx_q;
   logic [7:0]  xor_q;
   logic [31:0] tmo_q;
   logic [31:0] tmo_d;
   logic [31:0] baud_q;
   logic        wr_en_q;
   logic [7:0]  wr_addr_q;
   logic [31:0] wr_data_q;
   logic        frame_err_q;
   logic [1:0]  err_code_q;
   logic [15:0] frame_cnt_q;

   logic tmo_hit;
   logic sync_hit;
   logic baud_ok;

   always_comb begin
      tmo_d = tmo_q + 32'd1;
      if (i_Rx_DV || state_q == S_IDLE) begin
         tmo_d = '0;
      end
   end

   // A byte strobe always wins over expiry because every state checks i_Rx_DV first.
   assign tmo_hit  = (tmo_q == TMO_LAST);
   assign sync_hit = i_Rx_DV && (i_Rx_Byte == SYNC_BYTE);
   assign baud_ok  = (data_q >= BAUD_MIN) && (data_q <= BAUD_MAX);

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q     <= S_IDLE;
         cmd_q       <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         idx_q       <= '0;
         xor_q       <= '0;
         tmo_q       <= '0;
         baud_q      <= BAUD_RST;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         frame_err_q <= 1'b0;
         err_code_q  <= '0;
         frame_cnt_q <= '0;
      end else begin
         wr_en_q     <= 1'b0;
         frame_err_q <= 1'b0;
         tmo_q       <= tmo_d;
         unique case (state_q)
            // EXEC shares the SYNC check with IDLE so a back-to-back frame loses no byte.
            S_IDLE, S_EXEC: begin
               if (sync_hit) begin
                  state_q <= S_CMD;
                  xor_q   <= '0;
                  idx_q   <= '0;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_CMD: begin
               if (i_Rx_DV) begin
                  cmd_q   <= i_Rx_Byte;
                  xor_q   <= xor_q ^ i_Rx_Byte;
                  state_q <= S_ADDR;
               end else if (tmo_hit) begin
                  state_q     <= S_IDLE;
                  frame_err_q <= 1'b1;
                  err_code_q  <= 2'd1;
               end
            end
            S_ADDR: begin
               if (i_Rx_DV) begin
                  addr_q  <= i_Rx_Byte;
                  xor_q   <= xor_q ^ i_Rx_Byte;
                  state_q <= S_DATA;
               end else if (tmo_hit) begin
                  state_q     <= S_IDLE;
                  frame_err_q <= 1'b1;
                  err_code_q  <= 2'd1;
               end
            end
            S_DATA: begin
               if (i_Rx_DV) begin
                  data_q[{idx_q, 3'b000} +: 8] <= i_Rx_Byte;
                  xor_q <= xor_q ^ i_Rx_Byte;
                  idx_q <= idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                     state_q <= S_CHK;
                  end
               end else if (tmo_hit) begin
                  state_q     <= S_IDLE;
                  frame_err_q <= 1'b1;
                  err_code_q  <= 2'd1;
               end
            end
            S_CHK: begin
               if (i_Rx_DV) begin
                  state_q <= S_EXEC;
                  if (i_Rx_Byte != xor_q) begin
                     frame_err_q <= 1'b1;
                     err_code_q  <= 2'd2;
                  end else if (cmd_q == CMD_WRITE) begin
                     wr_en_q     <= 1'b1;
                     wr_addr_q   <= addr_q;
                     wr_data_q   <= data_q;
                     frame_cnt_q <= frame_cnt_q + 16'd1;
                  end else if (cmd_q == CMD_BAUD && baud_ok) begin
                     baud_q      <= data_q;
                     frame_cnt_q <= frame_cnt_q + 16'd1;
                  end else begin
                     frame_err_q <= 1'b1;
                     err_code_q  <= 2'd3;
                  end
               end else if (tmo_hit) begin
                  state_q     <= S_IDLE;
                  frame_err_q <= 1'b1;
                  err_code_q  <= 2'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_Baudrate  = baud_q;
   assign o_Wr_En     = wr_en_q;
   assign o_Wr_Addr   = wr_addr_q;
   assign o_Wr_Data   = wr_data_q;
   assign o_Frame_Err = frame_err_q;
   assign o_Err_Code  = err_code_q;
   assign o_Busy      = (state_q != S_IDLE);
   assign o_Frame_Cnt = frame_cnt_q;

endmodule
